// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and elaboration-time sizing helpers for seq_mult_sliced
package mult_pkg;
  typedef enum logic {IDLE, CALC} state_t;
  function automatic int num_slices(input int width, input int slice);
    return width / slice;
  endfunction
  function automatic int sel_width(input int n);
    return (2 * n - 1) > 1 ? $clog2(2 * n - 1) : 1;
  endfunction
  function automatic bit widths_ok(input int width, input int slice);
    return slice >= 1 && slice <= width && width % slice == 0;
  endfunction
endpackage

// File: rtl/seq_mult_sliced_pp_shifter.sv
// pp_shifter: zero-extend partial product pp to 2*WIDTH and shift left by sel*SLICE (sel > 2N-2 passes pp unshifted)
module pp_shifter
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4,
  localparam int N = num_slices(WIDTH, SLICE),
  localparam int SW = sel_width(N)
) (
  input  logic [2*SLICE-1:0] pp,
  input  logic [SW-1:0]      sel,
  output logic [2*WIDTH-1:0] shifted
);
  localparam int MAX_SEL = 2 * N - 2;
  logic [2*WIDTH-1:0] ext;
  always_comb begin
    ext = (2*WIDTH)'(pp);
    shifted = (int'(sel) > MAX_SEL) ? ext : ext << (int'(sel) * SLICE);
  end
endmodule

// File: rtl/seq_mult_sliced.sv
// seq_mult_sliced: sliced sequential multiplier; ports clk, reset(async high), start, a, b -> busy, done(pulse), product(held)
module seq_mult_sliced
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int N = num_slices(WIDTH, SLICE);
  localparam int SW = sel_width(N);
  localparam int CW = $clog2(N * N) + 1;
  localparam logic [CW-1:0] N_C = CW'(N);
  localparam logic [CW-1:0] LAST = CW'(N * N - 1);
  if (!widths_ok(WIDTH, SLICE)) begin : g_bad_widths
    $error("seq_mult_sliced: WIDTH must be a positive multiple of SLICE");
  end
  state_t             state;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*WIDTH-1:0] acc, pp_sh, sum;
  logic [CW-1:0]      cnt, i, j;
  logic [SLICE-1:0]   a_s, b_s;
  logic [2*SLICE-1:0] pp;
  logic [SW-1:0]      sel;
  always_comb begin
    i = cnt % N_C;
    j = cnt / N_C;
    a_s = a_r[i*SLICE +: SLICE];
    b_s = b_r[j*SLICE +: SLICE];
    pp = (2*SLICE)'(a_s) * (2*SLICE)'(b_s);
    sel = SW'(i + j);
    sum = acc + pp_sh;
  end
  pp_shifter #(.WIDTH(WIDTH), .SLICE(SLICE)) u_shift (.pp(pp), .sel(sel), .shifted(pp_sh));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      product <= '0;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && (a == '0 || b == '0)) begin
          product <= '0;
          done <= 1'b1;
        end else if (start) begin
          a_r <= a;
          b_r <= b;
          acc <= '0;
          cnt <= '0;
          state <= CALC;
          busy <= 1'b1;
        end
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          product <= sum;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_mult_sliced.sv
// tb_seq_mult_sliced: directed self-checking bench for three seq_mult_sliced configurations
module tb_seq_mult_sliced;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic s0, s1, s2;
  logic [7:0] a0, b0, a2, b2;
  logic [15:0] a1, b1;
  logic busy0, done0, busy1, done1, busy2, done2;
  logic [15:0] p0, p2;
  logic [31:0] p1;
  int n_cmp = 0;
  int n_err = 0;
  seq_mult_sliced #(.WIDTH(8), .SLICE(4)) u0 (.clk(clk), .reset(reset), .start(s0), .a(a0), .b(b0), .busy(busy0), .done(done0), .product(p0));
  seq_mult_sliced #(.WIDTH(16), .SLICE(4)) u1 (.clk(clk), .reset(reset), .start(s1), .a(a1), .b(b1), .busy(busy1), .done(done1), .product(p1));
  seq_mult_sliced #(.WIDTH(8), .SLICE(8)) u2 (.clk(clk), .reset(reset), .start(s2), .a(a2), .b(b2), .busy(busy2), .done(done2), .product(p2));
  task automatic test_reset;
    reset = 1'b1;
    {s0, s1, s2} = 3'b000;
    {a0, b0, a2, b2, a1, b1} = '0;
    @(negedge clk);
    n_cmp++; if ({busy0, done0, p0} !== 18'h0) begin n_err++; $display("FAIL reset_u0 got %h want 0", {busy0, done0, p0}); end
    n_cmp++; if ({busy1, done1, p1} !== 34'h0) begin n_err++; $display("FAIL reset_u1 got %h want 0", {busy1, done1, p1}); end
    n_cmp++; if ({busy2, done2, p2} !== 18'h0) begin n_err++; $display("FAIL reset_u2 got %h want 0", {busy2, done2, p2}); end
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_full_product;
    a0 = 8'hFF; b0 = 8'hFF; s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({busy0, done0} !== 2'b10) begin n_err++; $display("FAIL ff_busy%0d got %b want 10", k, {busy0, done0}); end
      @(negedge clk);
    end
    n_cmp++; if ({busy0, done0, p0} !== {2'b01, 16'hFE01}) begin n_err++; $display("FAIL ff_done got %b/%h want 01/fe01", {busy0, done0}, p0); end
    @(negedge clk);
    n_cmp++; if ({done0, p0} !== {1'b0, 16'hFE01}) begin n_err++; $display("FAIL ff_hold got %b/%h want 0/fe01", done0, p0); end
  endtask
  task automatic test_fast_path;
    a0 = 8'h00; b0 = 8'h5A; s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    n_cmp++; if ({busy0, done0, p0} !== {2'b01, 16'h0000}) begin n_err++; $display("FAIL zero_done got %b/%h want 01/0000", {busy0, done0}, p0); end
    @(negedge clk);
    n_cmp++; if ({busy0, done0} !== 2'b00) begin n_err++; $display("FAIL zero_after got %b want 00", {busy0, done0}); end
    a0 = 8'h12; b0 = 8'h34; s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({busy0, done0} !== 2'b10) begin n_err++; $display("FAIL mul1234_busy%0d got %b want 10", k, {busy0, done0}); end
      @(negedge clk);
    end
    n_cmp++; if ({done0, p0} !== {1'b1, 16'h03A8}) begin n_err++; $display("FAIL mul1234 got %b/%h want 1/03a8", done0, p0); end
  endtask
  task automatic test_back_to_back;
    @(negedge clk);
    a0 = 8'h0F; b0 = 8'h10; s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL b2b_busy0 got %b want 1", busy0); end
    @(negedge clk);
    a0 = 8'hFF; b0 = 8'hFF; s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    n_cmp++; if ({busy0, done0} !== 2'b10) begin n_err++; $display("FAIL b2b_busy2 got %b want 10", {busy0, done0}); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({busy0, done0, p0} !== {2'b01, 16'h00F0}) begin n_err++; $display("FAIL b2b_first got %b/%h want 01/00f0", {busy0, done0}, p0); end
    a0 = 8'h02; b0 = 8'h03; s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({busy0, done0} !== 2'b10) begin n_err++; $display("FAIL b2b_second_busy%0d got %b want 10", k, {busy0, done0}); end
      @(negedge clk);
    end
    n_cmp++; if ({done0, p0} !== {1'b1, 16'h0006}) begin n_err++; $display("FAIL b2b_second got %b/%h want 1/0006", done0, p0); end
  endtask
  task automatic test_reset_mid;
    logic stray;
    a0 = 8'hAB; b0 = 8'hCD; s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({busy0, done0, p0} !== 18'h0) begin n_err++; $display("FAIL midreset got %b/%h want 00/0000", {busy0, done0}, p0); end
    #1 reset = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      stray = stray | done0 | busy0;
    end
    n_cmp++; if (stray !== 1'b0) begin n_err++; $display("FAIL midreset_quiet got %b want 0", stray); end
    a0 = 8'hAB; b0 = 8'hCD; s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({busy0, done0} !== 2'b10) begin n_err++; $display("FAIL abcd_busy%0d got %b want 10", k, {busy0, done0}); end
      @(negedge clk);
    end
    n_cmp++; if ({done0, p0} !== {1'b1, 16'h88EF}) begin n_err++; $display("FAIL abcd got %b/%h want 1/88ef", done0, p0); end
  endtask
  task automatic test_wide;
    a1 = 16'hFFFF; b1 = 16'hFFFF; s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if ({busy1, done1} !== 2'b10) begin n_err++; $display("FAIL wide_busy%0d got %b want 10", k, {busy1, done1}); end
      @(negedge clk);
    end
    n_cmp++; if ({busy1, done1, p1} !== {2'b01, 32'hFFFE0001}) begin n_err++; $display("FAIL wide got %b/%h want 01/fffe0001", {busy1, done1}, p1); end
    @(negedge clk);
    n_cmp++; if ({done1, p1} !== {1'b0, 32'hFFFE0001}) begin n_err++; $display("FAIL wide_hold got %b/%h want 0/fffe0001", done1, p1); end
  endtask
  task automatic test_full_slice;
    a2 = 8'd200; b2 = 8'd3; s2 = 1'b1;
    @(negedge clk);
    s2 = 1'b0;
    n_cmp++; if ({busy2, done2} !== 2'b10) begin n_err++; $display("FAIL slice8_busy got %b want 10", {busy2, done2}); end
    @(negedge clk);
    n_cmp++; if ({busy2, done2, p2} !== {2'b01, 16'd600}) begin n_err++; $display("FAIL slice8 got %b/%0d want 01/600", {busy2, done2}, p2); end
  endtask
  initial begin
    test_reset();
    test_full_product();
    test_fast_path();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    test_full_slice();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_mult_sliced.md
Name: seq_mult_sliced

Overview:
Parametrised sequential unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Each operand is split into N = WIDTH/SLICE slices.
- One SLICE x SLICE partial product is computed per clock, shifted by a multiple of SLICE and accumulated, so a full product takes N*N cycles.
- It generalises the fixed 8x8 nibble scheme (shifts of 0/4/8) to any width and slice size.
- It adds a start/busy/done handshake, operand capture and a zero-operand fast path.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of SLICE.
SLICE, 4, slice width in bits; must satisfy 1 <= SLICE <= WIDTH.

Ports:
clk  in  1  clock; all flops update on the rising edge.
reset  in  1  asynchronous, active-high; clears all state.
start  in  1  request; sampled only in IDLE.
a  in  WIDTH  multiplicand; captured on accepted start.
b  in  WIDTH  multiplier; captured on accepted start.
busy  out  1  high while in CALC.
done  out  1  one-cycle pulse when the product becomes valid.
product  out  2*WIDTH  result register; holds until the next completion.

Behaviour:
- Reset (asynchronous, active-high), including mid-operation:
  - state=IDLE; busy=0; done=0; product=0; a_r, b_r, acc and cnt all 0.
  - The operation in progress is discarded; no done is issued.
- States: IDLE, CALC.
- IDLE, edge with start=1, a!=0 and b!=0 (edge E0):
  - a_r<=a, b_r<=b, acc<=0, cnt<=0, state<=CALC, busy<=1.
- IDLE, edge with start=1 and a==0 or b==0 (fast path):
  - product<=0, done<=1, state stays IDLE, busy stays 0.
  - Latency is 1 cycle.
- CALC, one step per edge:
  - i = cnt mod N selects the a_r slice; j = cnt div N selects the b_r slice. Slice k = bits [k*SLICE +: SLICE].
  - pp = a_r slice i * b_r slice j, zero-extended to 2*WIDTH and shifted left by (i+j)*SLICE.
  - acc <= acc + pp; cnt <= cnt + 1.
- CALC, final step (edge where cnt == N*N-1, i.e. edge E_{N*N}):
  - product <= acc + pp; done <= 1; busy <= 0; state <= IDLE.
  - Latency from the start edge to done is N*N cycles (4 for the defaults).
- Widths and overflow:
  - acc and product are 2*WIDTH bits; no overflow is possible.
  - cnt is $clog2(N*N)+1 bits.
- done is high for exactly one cycle, then returns to 0.
- product keeps its value indefinitely and is not cleared by a new start.
- start while busy is ignored: it is not queued and the captured operands are unchanged.
- Back-to-back: start=1 in the cycle where done=1 is accepted, because the block is already in IDLE.
- a and b may change freely after the start edge.
- SLICE==WIDTH: N=1, so a full product takes 1 CALC cycle.

Decomposition:
- Package mult_pkg:
  - state enum IDLE/CALC.
  - Helper functions for N = WIDTH/SLICE and shift-select width = $clog2(2N-1), minimum 1.
  - Elaboration-time check that WIDTH % SLICE == 0; fail elaboration otherwise.
- Sub-module pp_shifter (parameters WIDTH, SLICE): purely combinational.
  - Inputs: pp (2*SLICE bits) and sel (shift-select width).
  - Output: 2*WIDTH bits = pp << (sel*SLICE).
  - sel values above 2N-2 output unshifted pp; this mirrors the existing default-case convention.
- The FSM, counter, slice selection and accumulator live in seq_mult_sliced.

Test Plan:
- Defaults; reset then start with a=8'hFF, b=8'hFF -> busy high for 4 cycles; done pulse on the 4th edge after start; product=16'hFE01; done low next cycle; product held.
- Defaults; a=8'd0, b=8'h5A, start -> done on the next edge, busy never high, product=0. Then a=8'h12, b=8'h34 -> product=16'h03A8 after 4 cycles.
- Defaults; a=8'h0F, b=8'h10, start; assert start again with a=8'hFF, b=8'hFF in cycle 2 -> ignored; product=16'h00F0. Then start held in the done cycle with a=8'h02, b=8'h03 -> product=16'h0006 four cycles later.
- Defaults; start a=8'hAB, b=8'hCD; assert reset for a partial cycle after 2 edges -> busy, done and product go 0 immediately; no done after release. A fresh start gives product=16'h88EF.
- WIDTH=16, SLICE=4; a=16'hFFFF, b=16'hFFFF -> done after 16 cycles, product=32'hFFFE0001.
- WIDTH=8, SLICE=8; a=8'd200, b=8'd3 -> done after 1 cycle, product=16'd600.
